// File: rtl/lopd_share_arbiter.sv
// Round-robin arbiter sharing one pipelined LOPD between NUM_REQ requesters, with tag-checked
// response routing and a drain FSM. Optional macro LOPD_ARB_URGENT_EN adds an urgent-priority input.
module lopd_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_DATA = 32,
    parameter int SIZE_LOP  = $clog2(SIZE_DATA),
    parameter int LOPD_LAT  = 1,
    parameter int REQ_W     = $clog2(NUM_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data,
`ifdef LOPD_ARB_URGENT_EN
    input  logic [NUM_REQ-1:0]           i_req_urgent,
`endif
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic [NUM_REQ-1:0]           o_rsp_valid,
    output logic [SIZE_LOP-1:0]          o_rsp_position,
    output logic                         o_rsp_zero,
    output logic [SIZE_DATA-1:0]         o_lopd_addr,
    output logic [SIZE_DATA-1:0]         o_lopd_data,
    input  logic [SIZE_DATA-1:0]         i_lopd_addr,
    input  logic [SIZE_LOP-1:0]          i_lopd_position,
    input  logic                         i_lopd_zero,
    input  logic                         i_drain,
    output logic                         o_drained,
    output logic                         o_tag_err
);

    localparam int IF_W = $clog2(LOPD_LAT + 2);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [REQ_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]        seq_q;
    logic [IF_W-1:0]   in_flight_q, in_flight_d;
    logic              tag_err_q;

    logic              pipe_vld_q [LOPD_LAT];
    logic [1:0]        pipe_seq_q [LOPD_LAT];
    logic [REQ_W-1:0]  pipe_idx_q [LOPD_LAT];

    logic              can_grant, grant, rr_upd;
    logic [REQ_W-1:0]  gnt_idx;
    logic [REQ_W:0]    cand;
    logic              rsp_due, tag_bad;
    logic [REQ_W-1:0]  rsp_idx;
    logic              lopd_addr_hi_unused;

    // Only the low tag bits are meaningful on the echoed address.
    assign lopd_addr_hi_unused = ^i_lopd_addr[SIZE_DATA-1:REQ_W+2];

    assign can_grant = (state_q != DRAIN) && !i_drain && !i_rst;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        rr_upd  = 1'b1;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (REQ_W+1)'(i);
            if (cand >= (REQ_W+1)'(NUM_REQ))
                cand = cand - (REQ_W+1)'(NUM_REQ);
            if (!grant && i_req_valid[cand[REQ_W-1:0]]) begin
                grant   = 1'b1;
                gnt_idx = cand[REQ_W-1:0];
            end
        end
`ifdef LOPD_ARB_URGENT_EN
        // Urgent requesters bypass the rotation; lowest index wins and the pointer stays put.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && i_req_urgent[i]) begin
                grant   = 1'b1;
                gnt_idx = REQ_W'(i);
                rr_upd  = 1'b0;
            end
        end
`endif
        grant = grant && can_grant;
    end

    assign o_req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign o_lopd_addr = grant ? SIZE_DATA'({seq_q, gnt_idx}) : '0;
    assign o_lopd_data = grant ? i_req_data[gnt_idx*SIZE_DATA +: SIZE_DATA] : '0;

    assign rsp_due        = pipe_vld_q[LOPD_LAT-1];
    assign rsp_idx        = pipe_idx_q[LOPD_LAT-1];
    assign tag_bad        = rsp_due && (i_lopd_addr[REQ_W+1:0] != {pipe_seq_q[LOPD_LAT-1], rsp_idx});
    assign o_rsp_valid    = rsp_due ? (NUM_REQ'(1) << rsp_idx) : '0;
    assign o_rsp_position = rsp_due ? i_lopd_position : '0;
    assign o_rsp_zero     = rsp_due && i_lopd_zero;
    assign o_drained      = (state_q == DRAIN) && (in_flight_q == '0);
    assign o_tag_err      = tag_err_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant && rr_upd)
            rr_ptr_d = (gnt_idx == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        case ({grant, rsp_due})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_drain) state_d = DRAIN;
                     else if (grant) state_d = BUSY;
            BUSY:    if (i_drain) state_d = DRAIN;
                     else if (in_flight_d == '0 && !grant) state_d = IDLE;
            DRAIN:   if (!i_drain && in_flight_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            seq_q       <= '0;
            in_flight_q <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            in_flight_q <= in_flight_d;
            if (grant) seq_q <= seq_q + 2'd1;
            if (tag_bad) tag_err_q <= 1'b1;
        end
    end

    // NOTE: the shadow tag pipe is reset so responses for pre-reset tags can never be issued.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LOPD_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_seq_q[i] <= '0;
                pipe_idx_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= grant;
            pipe_seq_q[0] <= seq_q;
            pipe_idx_q[0] <= gnt_idx;
            for (int i = 1; i < LOPD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_seq_q[i] <= pipe_seq_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_lopd_share_arbiter.sv
// Directed bench for lopd_share_arbiter with a 1-cycle behavioural LOPD that can corrupt the echoed tag.
module tb_lopd_share_arbiter;

    localparam int NR = 4;
    localparam int SD = 32;
    localparam int SL = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*SD-1:0] req_data = '0;
`ifdef LOPD_ARB_URGENT_EN
    logic [NR-1:0]    req_urgent = '0;
`endif
    logic [NR-1:0]    req_ready, rsp_valid;
    logic [SL-1:0]    rsp_position;
    logic             rsp_zero;
    logic [SD-1:0]    lopd_addr_o, lopd_data_o;
    logic [SD-1:0]    lopd_addr_q, lopd_data_q;
    logic [SL-1:0]    lopd_pos;
    logic             lopd_zero;
    logic             drain = 1'b0;
    logic             drained, tag_err;
    logic             corrupt = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lopd_share_arbiter #(.NUM_REQ(NR), .SIZE_DATA(SD), .LOPD_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_data(req_data),
`ifdef LOPD_ARB_URGENT_EN
        .i_req_urgent(req_urgent),
`endif
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid),
        .o_rsp_position(rsp_position), .o_rsp_zero(rsp_zero),
        .o_lopd_addr(lopd_addr_o), .o_lopd_data(lopd_data_o),
        .i_lopd_addr(lopd_addr_q), .i_lopd_position(lopd_pos), .i_lopd_zero(lopd_zero),
        .i_drain(drain), .o_drained(drained), .o_tag_err(tag_err)
    );

    // Stand-in for the LOPD unit: one register stage, optional corruption of tag bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lopd_addr_q <= '0;
            lopd_data_q <= '0;
        end else begin
            lopd_addr_q <= lopd_addr_o ^ {31'b0, corrupt};
            lopd_data_q <= lopd_data_o;
        end
    end

    always_comb begin
        lopd_pos = '0;
        for (int i = 0; i < SD; i++)
            if (lopd_data_q[i]) lopd_pos = SL'(i);
    end
    assign lopd_zero = (lopd_data_q == '0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int exp_gnt [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int exp_seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int pos_of  [4] = '{4, 7, 10, 13};

    initial begin
        // Reset state, with a request already pending
        req_valid = 4'b0001;
        #2;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp", 32'(rsp_valid), 0);
        check("rst_drained", 32'(drained), 0);
        check("rst_tag_err", 32'(tag_err), 0);
        check("rst_lopd_data", lopd_data_o, 0);
        req_valid = '0;
        cyc(); rst = 1'b0;

        // T1: single request, response one cycle later
        cyc(); req_valid = 4'b0001; req_data[0 +: SD] = 32'h0000_0100; #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        check("t1_addr", lopd_addr_o, 0);
        check("t1_data", lopd_data_o, 32'h100);
        cyc(); req_valid = '0; #1;
        check("t1_rsp", 32'(rsp_valid), 32'b0001);
        check("t1_pos", 32'(rsp_position), 8);
        check("t1_zero", 32'(rsp_zero), 0);
        check("t1_nodata", lopd_data_o, 0);
        cyc(); #1;
        check("t1_rsp_off", 32'(rsp_valid), 0);

        // T2: all valid, rotation starts at rr_ptr=1
        for (int k = 0; k < NR; k++) req_data[k*SD +: SD] = 32'h1 << pos_of[k];
        for (int i = 0; i < 8; i++) begin
            cyc(); req_valid = 4'b1111; #1;
            check($sformatf("t2_ready%0d", i), 32'(req_ready), 32'(1) << exp_gnt[i]);
            check($sformatf("t2_addr%0d", i), lopd_addr_o, 32'((exp_seq[i] << 2) | exp_gnt[i]));
            if (i == 0) begin
                check("t2_rsp0", 32'(rsp_valid), 0);
            end else begin
                check($sformatf("t2_rsp%0d", i), 32'(rsp_valid), 32'(1) << exp_gnt[i-1]);
                check($sformatf("t2_pos%0d", i), 32'(rsp_position), 32'(pos_of[exp_gnt[i-1]]));
            end
        end
        cyc(); req_valid = '0; #1;
        check("t2_rsp_last", 32'(rsp_valid), 32'b0001);
        check("t2_pos_last", 32'(rsp_position), 4);

        // T3: zero operand on requester 2
        cyc(); req_valid = 4'b0100; req_data[2*SD +: SD] = '0; #1;
        check("t3_ready", 32'(req_ready), 32'b0100);
        check("t3_addr", lopd_addr_o, 32'h6);
        cyc(); req_valid = '0; #1;
        check("t3_rsp", 32'(rsp_valid), 32'b0100);
        check("t3_zero", 32'(rsp_zero), 1);
        check("t3_pos", 32'(rsp_position), 0);

        // T4: drain with one in flight
        cyc(); req_valid = 4'b0001; req_data[0 +: SD] = 32'h8000_0000; #1;
        check("t4_ready", 32'(req_ready), 32'b0001);
        check("t4_addr", lopd_addr_o, 32'h8);
        cyc(); drain = 1'b1; req_valid = 4'b1111; #1;
        check("t4_blocked", 32'(req_ready), 0);
        check("t4_rsp", 32'(rsp_valid), 32'b0001);
        check("t4_pos", 32'(rsp_position), 31);
        check("t4_not_drained", 32'(drained), 0);
        cyc(); #1;
        check("t4_drained", 32'(drained), 1);
        check("t4_ready_drain", 32'(req_ready), 0);
        check("t4_rsp_off", 32'(rsp_valid), 0);
        cyc(); drain = 1'b0; #1;
        check("t4_release_ready", 32'(req_ready), 0);
        check("t4_release_drained", 32'(drained), 1);
        cyc(); #1;
        check("t4_resume_ready", 32'(req_ready), 32'b0010);
        check("t4_resume_addr", lopd_addr_o, 32'hD);
        check("t4_idle_drained", 32'(drained), 0);
        cyc(); req_valid = '0; #1;
        check("t4_resume_rsp", 32'(rsp_valid), 32'b0010);
        check("t4_resume_pos", 32'(rsp_position), 7);

`ifdef LOPD_ARB_URGENT_EN
        // T6: set rr_ptr=1, then urgent requester 3 beats round-robin
        cyc(); req_valid = 4'b0001; #1;
        check("t6_setup", 32'(req_ready), 32'b0001);
        cyc(); req_valid = 4'b1010; req_urgent = 4'b1000; #1;
        check("t6_urgent", 32'(req_ready), 32'b1000);
        cyc(); req_urgent = '0; #1;
        check("t6_rr", 32'(req_ready), 32'b0010);
        check("t6_rsp", 32'(rsp_valid), 32'b1000);
        cyc(); req_valid = '0; #1;
        check("t6_rsp_rr", 32'(rsp_valid), 32'b0010);
`endif

        // T5: corrupted echoed tag sets a sticky error
        check("t5_pre_err", 32'(tag_err), 0);
        cyc(); req_valid = 4'b1000; corrupt = 1'b1; #1;
        check("t5_ready", 32'(req_ready), 32'b1000);
        cyc(); req_valid = '0; corrupt = 1'b0; #1;
        check("t5_rsp", 32'(rsp_valid), 32'b1000);
        cyc(); #1;
        check("t5_err_set", 32'(tag_err), 1);
        cyc(); cyc(); #1;
        check("t5_err_sticky", 32'(tag_err), 1);

        // Reset mid-operation discards the in-flight result
        cyc(); req_valid = 4'b1000; #1;
        check("rst_mid_ready", 32'(req_ready), 32'b1000);
        @(posedge clk); #1; rst = 1'b1; #1;
        check("rst_mid_rsp", 32'(rsp_valid), 0);
        check("rst_mid_err", 32'(tag_err), 0);
        check("rst_mid_ready_off", 32'(req_ready), 0);
        cyc(); rst = 1'b0; req_valid = '0; #1;
        check("post_rst_rsp", 32'(rsp_valid), 0);
        cyc(); req_valid = 4'b0010; #1;
        check("post_rst_ready", 32'(req_ready), 32'b0010);
        check("post_rst_addr", lopd_addr_o, 32'h1);
        cyc(); req_valid = '0; #1;
        check("post_rst_rsp2", 32'(rsp_valid), 32'b0010);
        check("post_rst_err", 32'(tag_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
